ts_tx_gen: RTL and testbench
============================

# ts_tx_gen

Training-sequence transmitter for the LTSSM. It consumes the `ts_start`/`ts_info`/`speed` request from the core LTSSM FSM and drives per-lane 16-symbol TS1/TS2 ordered sets onto the PHY symbol interface, one symbol per lane per clock. The same TS repeats until a new request arrives or an idle state is requested. It also reports completed-TS counts, which the LTSSM uses for exit conditions such as "N TS sent".

## Interface
- `LANE_NUM`, 4: number of lanes.
- `N_FTS`, 8'd16: value placed in symbol 3.
- `CNT_W`, 11: width of `ts_cnt`.

- `clk`  in  1  system clock, one symbol per lane per cycle.
- `rst_n`  in  1  reset. One clock; reset is asynchronous and active-low.
- `ts_start`  in  1  single-cycle request pulse. Latches `ts_info`, `speed` and `link_num`.
- `ts_info`  in  8  requested LTSSM state [7:4] and substate [3:0].
- `speed`  in  6  advertised data-rate bits.
- `link_num`  in  8  link number used in Configuration substates.
- `tx_data`  out  8*LANE_NUM  symbol per lane; lane i is bits [8i+7:8i].
- `tx_k`  out  LANE_NUM  K-symbol flag per lane.
- `tx_elec_idle`  out  1  high when no TS is being sent.
- `ts_done`  out  1  one-cycle pulse when symbol 15 of a TS is driven.
- `ts_cnt`  out  CNT_W  completed TSs since the last accepted `ts_start`; saturates at all-ones.
- `busy`  out  1  FSM is in SEND.

## Operation
Decode of latched `ts_info` gives the kind, link field and lane field:
- 8'h10 (Poll.Active): TS1, link PAD, lane PAD.
- 8'h11 (Poll.Cfg): TS2, link PAD, lane PAD.
- 8'h20 (Cfg.LinkWidthStart): TS1, link `link_num`, lane PAD.
- 8'h21 (Cfg.LaneNum): TS1, link `link_num`, lane = lane index i.
- 8'h22 (Cfg.Complete): TS2, link `link_num`, lane = lane index i.
- Any other value, including all of state 0 (Detect): IDLE request.

Symbol layout per TS (symbol index s = 0..15):
- s0: COM 8'hBC, k=1.
- s1: link field.
- s2: lane field. PAD is 8'hF7 with k=1; numeric fields have k=0.
- s3: `N_FTS`.
- s4: {2'b00, speed}.
- s5: 8'h00.
- s6..s15: 8'h4A for TS1, 8'h45 for TS2.

FSM has two states:
- IDLE:
  - `tx_data`=0, `tx_k`=0, `tx_elec_idle`=1.
  - `ts_start` with a non-IDLE decode → SEND, with s=0 on the next cycle.
  - `ts_start` with an IDLE decode → stay in IDLE and clear `ts_cnt`.
- SEND:
  - s increments each cycle and wraps 15→0. The TS repeats indefinitely.
  - `ts_start` mid-TS is held in a one-deep pending register. The newest request overwrites an older pending one.
  - The pending request is applied at the next s=0 boundary. A TS is never truncated.
  - If the applied request decodes to IDLE, the FSM returns to IDLE instead of sending s0.
- Counter:
  - `ts_cnt` increments on each `ts_done` and saturates.
  - It clears to 0 when a request is applied.
  - If clear and increment happen in the same cycle, clear wins: the finishing old TS is not counted.

## Timing
- All outputs are registered.
- Reset values: `tx_data`=0, `tx_k`=0, `tx_elec_idle`=1, `ts_done`=0, `ts_cnt`=0, `busy`=0, pending cleared.
- Reset mid-TS takes effect immediately (asynchronously) and abandons the TS.
- From IDLE: `ts_start` in cycle N gives COM on `tx_data` in cycle N+1. `busy` and `tx_elec_idle`=0 also appear in cycle N+1.
- From SEND: `ts_start` in cycle N, with symbol 15 of the current TS in cycle M ≥ N, gives the new TS's s0 in cycle M+1. If `ts_start` arrives in the same cycle as symbol 15, the new TS starts the very next cycle.
- `ts_done` is high in the same cycle as s15.
- `ts_cnt` reflects that TS in the following cycle.
- A TS lasts exactly 16 cycles. Back-to-back TSs have no gap.
- All lanes are symbol-aligned. Lanes differ only in s2 when the lane field is numeric.

## Structure
- Shared package `ltssm_pkg` holds:
  - state/substate codes (DETECT=4'h0, POLL=4'h1, CFG=4'h2, and substate codes);
  - symbol constants COM, PAD, TS1_ID, TS2_ID;
  - the TS-kind enum.
- The core LTSSM FSM imports the same package.
- Sub-module `ts_sym_sel` is instantiated once per lane. It is combinational: it maps (s, kind, link field, lane field) to {k, data}. The parent registers its outputs.

## Test plan
- Reset, then `ts_start` with `ts_info`=8'h10 and `speed`=6'h02. Required: next cycle lane0 shows BC/k1, then F7/k1, F7/k1, 10, 02, 00, then 4A ×10. `ts_done` pulses at s15. `ts_cnt` reaches 1024 after 1024×16 cycles.
- While sending 8'h10, issue 8'h11 at s7. Required: the current TS1 completes, then TS2 with 45 ×10 starts with no gap, and `ts_cnt` restarts at 0.
- `ts_info`=8'h21 with `link_num`=8'h05. Required: s1=05/k0 on all lanes; s2 = 00, 01, 02, 03 on lanes 0–3 with k0.
- Issue `ts_start` exactly at s15. Required: the new TS begins the next cycle, and `ts_cnt`=0 (clear wins over increment).
- While sending, issue two requests (8'h11 at s3, then 8'h00 at s9). Required: only 8'h00 takes effect. After s15 the block goes IDLE, `tx_elec_idle`=1, `busy`=0.
- Assert `rst_n` low at s6. Required: outputs go to reset values asynchronously, and after release the block stays IDLE until a new `ts_start`.

Source files
------------

// File: rtl/ltssm_pkg.sv
// Shared LTSSM definitions: state/substate codes, TS symbol constants and the
// ts_info decode used by the core FSM and the training-sequence transmitter.
package ltssm_pkg;

  localparam logic [3:0] ST_DETECT = 4'h0;
  localparam logic [3:0] ST_POLL   = 4'h1;
  localparam logic [3:0] ST_CFG    = 4'h2;

  localparam logic [3:0] SUB_POLL_ACTIVE  = 4'h0;
  localparam logic [3:0] SUB_POLL_CFG     = 4'h1;
  localparam logic [3:0] SUB_CFG_LW_START = 4'h0;
  localparam logic [3:0] SUB_CFG_LANENUM  = 4'h1;
  localparam logic [3:0] SUB_CFG_COMPLETE = 4'h2;

  localparam logic [7:0] SYM_COM    = 8'hBC;
  localparam logic [7:0] SYM_PAD    = 8'hF7;
  localparam logic [7:0] SYM_TS1_ID = 8'h4A;
  localparam logic [7:0] SYM_TS2_ID = 8'h45;

  typedef enum logic [1:0] {
    TS_IDLE     = 2'd0,
    TS_KIND_TS1 = 2'd1,
    TS_KIND_TS2 = 2'd2
  } ts_kind_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

  typedef struct packed {
    ts_kind_e kind;
    logic     link_pad;
    logic     lane_pad;
  } ts_dec_t;

  function automatic ts_dec_t decode_ts_info(input logic [7:0] info);
    ts_dec_t d;
    d.kind     = TS_IDLE;
    d.link_pad = 1'b1;
    d.lane_pad = 1'b1;
    case (info[7:4])
      ST_DETECT: d.kind = TS_IDLE;
      ST_POLL: begin
        case (info[3:0])
          SUB_POLL_ACTIVE: d.kind = TS_KIND_TS1;
          SUB_POLL_CFG:    d.kind = TS_KIND_TS2;
          default:         d.kind = TS_IDLE;
        endcase
      end
      ST_CFG: begin
        case (info[3:0])
          SUB_CFG_LW_START: begin
            d.kind     = TS_KIND_TS1;
            d.link_pad = 1'b0;
          end
          SUB_CFG_LANENUM: begin
            d.kind     = TS_KIND_TS1;
            d.link_pad = 1'b0;
            d.lane_pad = 1'b0;
          end
          SUB_CFG_COMPLETE: begin
            d.kind     = TS_KIND_TS2;
            d.link_pad = 1'b0;
            d.lane_pad = 1'b0;
          end
          default: d.kind = TS_IDLE;
        endcase
      end
      default: d.kind = TS_IDLE;
    endcase
    return d;
  endfunction

  function automatic logic is_idle_req(input logic [7:0] info);
    ts_dec_t d;
    d = decode_ts_info(info);
    return d.kind == TS_IDLE;
  endfunction

endpackage

// File: rtl/ts_tx_gen_if.sv
// Request/PHY-symbol bundle between the LTSSM core and the TS transmitter.
interface ts_tx_gen_if #(
  parameter int LANE_NUM = 4,
  parameter int CNT_W    = 11
);
  logic                    ts_start;
  logic [7:0]              ts_info;
  logic [5:0]              speed;
  logic [7:0]              link_num;
  logic [8*LANE_NUM-1:0]   tx_data;
  logic [LANE_NUM-1:0]     tx_k;
  logic                    tx_elec_idle;
  logic                    ts_done;
  logic [CNT_W-1:0]        ts_cnt;
  logic                    busy;

  modport master (
    output ts_start, ts_info, speed, link_num,
    input  tx_data, tx_k, tx_elec_idle, ts_done, ts_cnt, busy
  );

  modport slave (
    input  ts_start, ts_info, speed, link_num,
    output tx_data, tx_k, tx_elec_idle, ts_done, ts_cnt, busy
  );
endinterface

// File: rtl/ts_sym_sel.sv
// Per-lane symbol mux: picks {k, data} for symbol index s of the active TS.
module ts_sym_sel
  import ltssm_pkg::*;
#(
  parameter logic [7:0] N_FTS = 8'd16
) (
  input  logic [3:0] sym_idx,
  input  ts_kind_e   kind,
  input  logic [8:0] link_fld,
  input  logic [8:0] lane_fld,
  input  logic [5:0] speed,
  output logic [8:0] sym
);

  always_comb begin
    sym = {1'b0, (kind == TS_KIND_TS2) ? SYM_TS2_ID : SYM_TS1_ID};
    case (sym_idx)
      4'd0:    sym = {1'b1, SYM_COM};
      4'd1:    sym = link_fld;
      4'd2:    sym = lane_fld;
      4'd3:    sym = {1'b0, N_FTS};
      4'd4:    sym = {3'b000, speed};
      4'd5:    sym = 9'h000;
      default: ;
    endcase
  end

endmodule

// File: rtl/ts_tx_gen.sv
// TS1/TS2 ordered-set transmitter: repeats the requested TS per lane, swaps
// requests only on TS boundaries, and counts completed TSs.
//
// state   | meaning
// IDLE    | electrical idle, outputs zero, waiting for a non-idle request
// SEND    | driving symbol sym_idx of the active TS on every lane
module ts_tx_gen
  import ltssm_pkg::*;
#(
  parameter int         LANE_NUM = 4,
  parameter logic [7:0] N_FTS    = 8'd16,
  parameter int         CNT_W    = 11
) (
  input logic        clk,
  input logic        rst_n,
  ts_tx_gen_if.slave bus
);

  tx_state_e  state, state_nxt;
  logic [3:0] sym_idx, sym_idx_nxt;
  logic [7:0] act_info, act_info_nxt;
  logic [7:0] act_link, act_link_nxt;
  logic [5:0] act_speed, act_speed_nxt;
  logic       pend_vld, pend_vld_nxt;
  logic [7:0] pend_info, pend_info_nxt;
  logic [7:0] pend_link, pend_link_nxt;
  logic [5:0] pend_speed, pend_speed_nxt;
  logic       cnt_clr;

  ts_dec_t               dec_nxt;
  logic [8:0]            link_fld;
  logic [8*LANE_NUM-1:0] data_sel;
  logic [LANE_NUM-1:0]   k_sel;

  logic [8*LANE_NUM-1:0] tx_data_q;
  logic [LANE_NUM-1:0]   tx_k_q;
  logic                  eidle_q, done_q, busy_q;
  logic [CNT_W-1:0]      cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sym_idx    <= 4'd0;
      act_info   <= 8'h00;
      act_link   <= 8'h00;
      act_speed  <= 6'h00;
      pend_vld   <= 1'b0;
      pend_info  <= 8'h00;
      pend_link  <= 8'h00;
      pend_speed <= 6'h00;
    end else begin
      state      <= state_nxt;
      sym_idx    <= sym_idx_nxt;
      act_info   <= act_info_nxt;
      act_link   <= act_link_nxt;
      act_speed  <= act_speed_nxt;
      pend_vld   <= pend_vld_nxt;
      pend_info  <= pend_info_nxt;
      pend_link  <= pend_link_nxt;
      pend_speed <= pend_speed_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    sym_idx_nxt    = sym_idx;
    act_info_nxt   = act_info;
    act_link_nxt   = act_link;
    act_speed_nxt  = act_speed;
    pend_vld_nxt   = pend_vld;
    pend_info_nxt  = pend_info;
    pend_link_nxt  = pend_link;
    pend_speed_nxt = pend_speed;
    cnt_clr        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.ts_start) begin
          cnt_clr      = 1'b1;
          pend_vld_nxt = 1'b0;
          if (!is_idle_req(bus.ts_info)) begin
            state_nxt     = ST_SEND;
            sym_idx_nxt   = 4'd0;
            act_info_nxt  = bus.ts_info;
            act_link_nxt  = bus.link_num;
            act_speed_nxt = bus.speed;
          end
        end
      end
      ST_SEND: begin
        if (sym_idx == 4'd15) begin
          // A request arriving on s15 itself is newer than anything pending.
          sym_idx_nxt  = 4'd0;
          pend_vld_nxt = 1'b0;
          if (bus.ts_start) begin
            cnt_clr       = 1'b1;
            act_info_nxt  = bus.ts_info;
            act_link_nxt  = bus.link_num;
            act_speed_nxt = bus.speed;
          end else if (pend_vld) begin
            cnt_clr       = 1'b1;
            act_info_nxt  = pend_info;
            act_link_nxt  = pend_link;
            act_speed_nxt = pend_speed;
          end
          if (is_idle_req(act_info_nxt)) state_nxt = ST_IDLE;
        end else begin
          sym_idx_nxt = sym_idx + 4'd1;
          if (bus.ts_start) begin
            pend_vld_nxt   = 1'b1;
            pend_info_nxt  = bus.ts_info;
            pend_link_nxt  = bus.link_num;
            pend_speed_nxt = bus.speed;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign dec_nxt  = decode_ts_info(act_info_nxt);
  assign link_fld = dec_nxt.link_pad ? {1'b1, SYM_PAD} : {1'b0, act_link_nxt};

  for (genvar i = 0; i < LANE_NUM; i++) begin : g_lane
    logic [8:0] lane_fld;
    logic [8:0] lane_sym;
    assign lane_fld = dec_nxt.lane_pad ? {1'b1, SYM_PAD} : {1'b0, 8'(i)};
    ts_sym_sel #(.N_FTS(N_FTS)) u_sym_sel (
      .sym_idx  (sym_idx_nxt),
      .kind     (dec_nxt.kind),
      .link_fld (link_fld),
      .lane_fld (lane_fld),
      .speed    (act_speed_nxt),
      .sym      (lane_sym)
    );
    assign k_sel[i]          = lane_sym[8];
    assign data_sel[8*i +: 8] = lane_sym[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q <= '0;
      tx_k_q    <= '0;
      eidle_q   <= 1'b1;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      tx_data_q <= (state_nxt == ST_SEND) ? data_sel : '0;
      tx_k_q    <= (state_nxt == ST_SEND) ? k_sel : '0;
      eidle_q   <= (state_nxt != ST_SEND);
      busy_q    <= (state_nxt == ST_SEND);
      done_q    <= (state_nxt == ST_SEND) && (sym_idx_nxt == 4'd15);
      // The TS finishing in the same cycle a new request lands is not counted.
      if (cnt_clr)
        cnt_q <= '0;
      else if (done_q && (cnt_q != {CNT_W{1'b1}}))
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.tx_data      = tx_data_q;
  assign bus.tx_k         = tx_k_q;
  assign bus.tx_elec_idle = eidle_q;
  assign bus.ts_done      = done_q;
  assign bus.ts_cnt       = cnt_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_ts_tx_gen.sv
// Directed bench for ts_tx_gen: expected per-cycle symbols are queued when a
// request is issued and compared against the lanes one cycle at a time.
module tb_ts_tx_gen;

  typedef struct packed {
    logic        eidle;
    logic        busy;
    logic        done;
    logic [3:0]  k;
    logic [31:0] data;
  } obs_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   step;
  obs_t exp_q[$];

  ts_tx_gen_if #(.LANE_NUM(4), .CNT_W(11)) bus ();

  ts_tx_gen #(.LANE_NUM(4), .N_FTS(8'd16), .CNT_W(11)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] exp_sym(input logic [7:0] info, input logic [5:0] spd,
                                         input logic [7:0] lnk, input int s, input int lane);
    logic is_ts2, link_num_f, lane_num_f;
    logic [7:0] lane_val;
    is_ts2     = (info == 8'h11) || (info == 8'h22);
    link_num_f = (info == 8'h20) || (info == 8'h21) || (info == 8'h22);
    lane_num_f = (info == 8'h21) || (info == 8'h22);
    lane_val   = 8'(lane);
    case (s)
      0:       return {1'b1, 8'hBC};
      1:       return link_num_f ? {1'b0, lnk} : {1'b1, 8'hF7};
      2:       return lane_num_f ? {1'b0, lane_val} : {1'b1, 8'hF7};
      3:       return {1'b0, 8'd16};
      4:       return {1'b0, 2'b00, spd};
      5:       return 9'h000;
      default: return {1'b0, is_ts2 ? 8'h45 : 8'h4A};
    endcase
  endfunction

  function automatic obs_t idle_obs();
    obs_t o;
    o.eidle = 1'b1; o.busy = 1'b0; o.done = 1'b0; o.k = 4'h0; o.data = 32'h0;
    return o;
  endfunction

  task automatic push_ts(input logic [7:0] info, input logic [5:0] spd, input logic [7:0] lnk);
    obs_t e;
    logic [8:0] sy;
    for (int s = 0; s < 16; s++) begin
      e.eidle = 1'b0;
      e.busy  = 1'b1;
      e.done  = (s == 15);
      for (int l = 0; l < 4; l++) begin
        sy = exp_sym(info, spd, lnk, s, l);
        e.k[l]           = sy[8];
        e.data[8*l +: 8] = sy[7:0];
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(idle_obs());
  endtask

  task automatic req(input logic [7:0] info, input logic [5:0] spd, input logic [7:0] lnk);
    bus.ts_start = 1'b1;
    bus.ts_info  = info;
    bus.speed    = spd;
    bus.link_num = lnk;
  endtask

  task automatic cyc();
    obs_t o, e;
    @(posedge clk);
    #1;
    bus.ts_start = 1'b0;
    step++;
    o = {bus.tx_elec_idle, bus.busy, bus.ts_done, bus.tx_k, bus.tx_data};
    checks++;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("FAIL sb_empty step=%0d observed=%h required=queued_entry", step, o);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      assert (o === e) else begin
        failures++;
        $error("FAIL sym step=%0d observed=%h required=%h", step, o, e);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_ts(input int n, input logic [7:0] info, input logic [5:0] spd,
                        input logic [7:0] lnk);
    for (int t = 0; t < n; t++) begin
      push_ts(info, spd, lnk);
      run(16);
    end
  endtask

  task automatic check_cnt(input string tag, input logic [10:0] exp_cnt);
    checks++;
    assert (bus.ts_cnt === exp_cnt) else begin
      failures++;
      $error("FAIL %s observed=%0d required=%0d", tag, bus.ts_cnt, exp_cnt);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    obs_t o;
    o = {bus.tx_elec_idle, bus.busy, bus.ts_done, bus.tx_k, bus.tx_data};
    checks++;
    assert (o === idle_obs()) else begin
      failures++;
      $error("FAIL %s observed=%h required=%h", tag, o, idle_obs());
    end
    check_cnt({tag, "_cnt"}, 11'd0);
  endtask

  initial begin
    checks = 0; failures = 0; step = 0;
    rst_n = 1'b0;
    bus.ts_start = 1'b0; bus.ts_info = 8'h00; bus.speed = 6'h00; bus.link_num = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    push_idle(2);
    run(2);

    // Idle-decoding requests while idle leave the link in electrical idle.
    req(8'h33, 6'h01, 8'h00);
    push_idle(2);
    run(2);
    req(8'h00, 6'h01, 8'h00);
    push_idle(2);
    run(2);

    // Poll.Active TS1 stream, count up to 1024 and on to saturation.
    req(8'h10, 6'h02, 8'h00);
    run_ts(1024, 8'h10, 6'h02, 8'h00);
    check_cnt("cnt_1023", 11'd1023);
    push_ts(8'h10, 6'h02, 8'h00);
    cyc();
    check_cnt("cnt_1024", 11'd1024);
    run(15);
    run_ts(1023, 8'h10, 6'h02, 8'h00);
    push_ts(8'h10, 6'h02, 8'h00);
    cyc();
    check_cnt("cnt_sat", 11'd2047);
    run(15);

    // Switch to TS2 mid-TS at s7: old TS completes, TS2 follows with no gap.
    push_ts(8'h10, 6'h02, 8'h00);
    run(8);
    req(8'h11, 6'h02, 8'h00);
    run(8);
    push_ts(8'h11, 6'h02, 8'h00);
    cyc();
    check_cnt("cnt_clr_switch", 11'd0);
    run(15);

    // Request exactly at s15 starts next cycle; clear beats increment.
    push_ts(8'h11, 6'h02, 8'h00);
    run(16);
    check_cnt("cnt_pre_s15", 11'd1);
    req(8'h21, 6'h3F, 8'h05);
    push_ts(8'h21, 6'h3F, 8'h05);
    cyc();
    check_cnt("cnt_clr_s15", 11'd0);
    run(15);
    push_ts(8'h21, 6'h3F, 8'h05);
    cyc();
    check_cnt("cnt_after_lanenum", 11'd1);
    run(15);

    // Two pending requests: the later idle request wins.
    push_ts(8'h21, 6'h3F, 8'h05);
    run(4);
    req(8'h11, 6'h3F, 8'h05);
    run(6);
    req(8'h00, 6'h3F, 8'h05);
    run(6);
    push_idle(4);
    run(4);
    check_cnt("cnt_idle_return", 11'd0);

    // Async reset at s6 with a request pending; stays idle afterwards.
    req(8'h10, 6'h02, 8'h00);
    run_ts(1, 8'h10, 6'h02, 8'h00);
    push_ts(8'h10, 6'h02, 8'h00);
    run(4);
    check_cnt("cnt_before_rst", 11'd1);
    req(8'h11, 6'h02, 8'h00);
    run(3);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    exp_q.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    push_idle(5);
    run(5);

    // Cfg.Complete TS2 with numeric link and lane fields.
    req(8'h22, 6'h15, 8'hAA);
    run_ts(1, 8'h22, 6'h15, 8'hAA);
    check_cnt("cnt_cfg_s15", 11'd0);
    push_ts(8'h22, 6'h15, 8'hAA);
    cyc();
    check_cnt("cnt_cfg_next", 11'd1);
    run(15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
